// File: rtl/nora_pkg.sv
// Shared NORA definitions: reset-sequencer state encoding and default cycle constants.
// Reused by the clock-enable and bus blocks.
package nora_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StSettle   = 2'd1,
        StCpuHold  = 2'd2,
        StRun      = 2'd3
    } rst_state_e;

    // 48 MHz system clock: 100 us settle, 2 us CPU hold, 1 ms button debounce.
    localparam int unsigned DefSettleCycles   = 4800;
    localparam int unsigned DefCpuHoldCycles  = 96;
    localparam int unsigned DefDebounceCycles = 48000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a debounce counter; level resets to 1 (released).
// The output changes only after the synchronized input holds the new level DEBOUNCE_CYCLES cycles.
module debounce_sync
    import nora_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level   <= 1'b1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            // Any sample matching the current level restarts the run.
            if (sync_q2 == level) begin
                cnt_q <= '0;
            end else if (cnt_q >= CntLast) begin
                level <= sync_q2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Power-up reset sequencer: waits for PLL lock, settles, releases the fabric, then the CPU.
// A debounced button press re-holds only the CPU; lock loss restarts the whole sequence.
module reset_seq
    import nora_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = DefSettleCycles,
    parameter int unsigned CPU_HOLD_CYCLES = DefCpuHoldCycles,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic resetn,
    input  logic pll_locked_i,
    input  logic btn_resetn_i,
    output logic sys_resetn_o,
    output logic cpu_resetn_o,
    output logic ready_o
);

    localparam int unsigned CntW = $clog2(max_u(SETTLE_CYCLES, CPU_HOLD_CYCLES)) + 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(CPU_HOLD_CYCLES - 1);

    logic            lock_q1;
    logic            lock_q2;
    logic            btn_level;
    rst_state_e      state_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q1 <= 1'b0;
            lock_q2 <= 1'b0;
        end else begin
            lock_q1 <= pll_locked_i;
            lock_q2 <= lock_q1;
        end
    end

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .resetn(resetn),
        .raw   (btn_resetn_i),
        .level (btn_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            sys_resetn_o <= 1'b0;
            cpu_resetn_o <= 1'b0;
            ready_o      <= 1'b0;
        end else if (!lock_q2) begin
            // Lock loss outranks everything, including a simultaneous button press.
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            sys_resetn_o <= 1'b0;
            cpu_resetn_o <= 1'b0;
            ready_o      <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    state_q <= StSettle;
                    cnt_q   <= '0;
                end
                StSettle: begin
                    if (cnt_q >= SettleLast) begin
                        state_q      <= StCpuHold;
                        cnt_q        <= '0;
                        sys_resetn_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StCpuHold: begin
                    if (!btn_level) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= HoldLast) begin
                        state_q      <= StRun;
                        cnt_q        <= '0;
                        cpu_resetn_o <= 1'b1;
                        ready_o      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!btn_level) begin
                        state_q      <= StCpuHold;
                        cnt_q        <= '0;
                        cpu_resetn_o <= 1'b0;
                        ready_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StWaitLock;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Randomized bench for reset_seq against a run-length reference model of the reset sequence.
module tb_reset_seq;

    localparam int unsigned S = 10;
    localparam int unsigned H = 4;
    localparam int unsigned D = 5;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic lock = 1'b1;
    logic btn = 1'b1;
    logic sys;
    logic cpu;
    logic rdy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reset_seq #(
        .SETTLE_CYCLES  (S),
        .CPU_HOLD_CYCLES(H),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_locked_i(lock),
        .btn_resetn_i(btn),
        .sys_resetn_o(sys),
        .cpu_resetn_o(cpu),
        .ready_o     (rdy)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: inputs delayed two edges; button level flips when the last D samples
    // all disagree; fabric released once lock has been seen for S+1 edges in a row; CPU
    // released once the debounced button has been seen high for H edges after that.
    bit m_lock1, m_lock2, m_btn1, m_btn2, m_deb, m_sys, m_cpu;
    int lock_run, high_run;
    bit hist[$];

    function automatic void model_reset();
        m_lock1 = 0; m_lock2 = 0; m_btn1 = 0; m_btn2 = 0;
        m_deb = 1; m_sys = 0; m_cpu = 0;
        lock_run = 0; high_run = 0;
        hist.delete();
    endfunction

    function automatic void model_edge();
        bit seen_lock, seen_deb, old_sys, flip;
        if (!resetn) begin
            model_reset();
            return;
        end
        seen_lock = m_lock2;
        seen_deb  = m_deb;
        old_sys   = m_sys;
        hist.push_back(m_btn2);
        if (hist.size() > D) void'(hist.pop_front());
        flip = (hist.size() == D);
        foreach (hist[i]) if (hist[i] == m_deb) flip = 0;
        if (flip) begin
            m_deb = !m_deb;
            hist.delete();
        end
        m_lock2 = m_lock1; m_lock1 = lock;
        m_btn2  = m_btn1;  m_btn1  = btn;
        lock_run = seen_lock ? ((lock_run < S + 1) ? lock_run + 1 : lock_run) : 0;
        m_sys = (lock_run >= S + 1);
        if (!m_sys || !old_sys) high_run = 0;
        else if (seen_deb) high_run = (high_run < H) ? high_run + 1 : high_run;
        else high_run = 0;
        m_cpu = m_sys && (high_run >= H);
    endfunction

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_eq({tag, ".sys"}, sys, m_sys);
        check_eq({tag, ".cpu"}, cpu, m_cpu);
        check_eq({tag, ".rdy"}, rdy, m_cpu);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Called just after an edge: outputs must drop before the next edge arrives.
    task automatic async_reset(input string tag);
        resetn = 1'b0;
        model_reset();
        #1;
        check_eq({tag, ".async_sys"}, sys, 1'b0);
        check_eq({tag, ".async_cpu"}, cpu, 1'b0);
        check_eq({tag, ".async_rdy"}, rdy, 1'b0);
        ticks({tag, ".held"}, 2);
        resetn = 1'b1;
    endtask

    initial begin
        int lock_t;
        int btn_t;
        model_reset();
        #2;
        resetn = 1'b0;
        #1;
        check_eq("por.sys", sys, 1'b0);
        check_eq("por.cpu", cpu, 1'b0);
        check_eq("por.rdy", rdy, 1'b0);
        ticks("por_held", 2);
        resetn = 1'b1;

        // Power-up: fabric at +13, CPU at +17.
        ticks("powerup", 25);
        check_eq("powerup.run", rdy, 1'b1);

        // Long button press re-holds only the CPU.
        btn = 1'b0;
        ticks("press", 8);
        btn = 1'b1;
        ticks("release", 20);

        // Bounce shorter than the debounce window.
        for (int p = 0; p < 4; p++) begin
            btn = 1'b0;
            ticks("bounce_lo", 3);
            btn = 1'b1;
            ticks("bounce_hi", 2);
        end
        ticks("bounce_end", 10);

        // One-cycle lock glitch reruns the full sequence.
        lock = 1'b0;
        tick("glitch");
        lock = 1'b1;
        ticks("relock", 25);

        // Reset in the middle of SETTLE (count 6), then a full restart.
        async_reset("pre_settle");
        ticks("settle", 9);
        async_reset("mid_settle");
        ticks("restart", 25);

        // Lock loss and debounced press seen on the same edge.
        btn = 1'b0;
        ticks("simul_press", 5);
        lock = 1'b0;
        tick("simul_drop");
        lock = 1'b1;
        ticks("simul_wait", 2);
        check_eq("simul.sys_low", sys, 1'b0);
        btn = 1'b1;
        ticks("simul_recover", 30);

        // Randomized lock drops and button activity.
        lock_t = 0;
        btn_t  = 0;
        for (int c = 0; c < 800; c++) begin
            if (lock_t == 0) begin
                lock   = ($urandom_range(0, 15) != 0);
                lock_t = lock ? $urandom_range(5, 40) : $urandom_range(1, 3);
            end
            if (btn_t == 0) begin
                btn   = ($urandom_range(0, 3) != 0);
                btn_t = $urandom_range(1, 10);
            end
            lock_t--;
            btn_t--;
            if (c % 200 == 199) async_reset("rand_rst");
            else tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
